// File: rtl/cpu_defs.sv
// Shared definitions for the control unit: opcodes, step states, opcode classes
// and the strobe bundle the step decoder produces.
package cpu_defs;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // *_DONE states are the single completion cycle after mem_done was seen.
  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T1_DONE, ST_T2, ST_T3, ST_T4, ST_T5,
    ST_T6, ST_T6_DONE, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_LD, CL_LDI, CL_ST, CL_ALU, CL_IMM, CL_MULDIV, CL_NEGNOT,
    CL_BR, CL_JR, CL_IN, CL_OUT, CL_MFLO, CL_MFHI, CL_HALT
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic ir_in;
    logic mdr_enable;
    logic mdr_read;
    logic mdr_out;
    logic mem_write;
    logic y_in;
    logic z_in;
    logic z_high_out;
    logic z_low_out;
    logic hi_in;
    logic lo_in;
    logic hi_out;
    logic lo_out;
    logic c_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic con_in;
    logic inport_out;
    logic outport_in;
    logic [OP_W-1:0] operation;
    logic run;
  } strobe_t;

  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    op_class_t cls;
    case (op) inside
      OP_LD:             cls = CL_LD;
      OP_LDI:            cls = CL_LDI;
      OP_ST:             cls = CL_ST;
      [OP_ADD:OP_SHL]:   cls = CL_ALU;
      [OP_ADDI:OP_ORI]:  cls = CL_IMM;
      OP_DIV, OP_MUL:    cls = CL_MULDIV;
      OP_NEG, OP_NOT:    cls = CL_NEGNOT;
      OP_BR:             cls = CL_BR;
      OP_JR:             cls = CL_JR;
      OP_IN:             cls = CL_IN;
      OP_OUT:            cls = CL_OUT;
      OP_MFLO:           cls = CL_MFLO;
      OP_MFHI:           cls = CL_MFHI;
      OP_HALT:           cls = CL_HALT;
      default:           cls = CL_NOP;
    endcase
    return cls;
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [OP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] alu;
    case (op)
      OP_ADDI: alu = OP_ADD;
      OP_ANDI: alu = OP_AND;
      default: alu = OP_OR;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/step_decoder.sv
// Combinational decode of (step state, opcode, con_ff) into the strobe bundle.
module step_decoder
  import cpu_defs::*;
(
  input  state_t              state,
  input  logic [OP_W-1:0]     opcode,
  input  logic                con_ff,
  output strobe_t             strobes
);

  op_class_t cls;

  assign cls = classify(opcode);

  always_comb begin
    strobes     = '0;
    strobes.run = 1'b1;
    case (state)
      ST_T0: begin
        strobes.pc_out = 1'b1; strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1; strobes.z_in   = 1'b1;
      end
      ST_T1: begin
        strobes.z_low_out = 1'b1; strobes.pc_in = 1'b1; strobes.mdr_read = 1'b1;
      end
      ST_T1_DONE: begin
        strobes.z_low_out  = 1'b1; strobes.pc_in = 1'b1; strobes.mdr_read = 1'b1;
        strobes.mdr_enable = 1'b1;
      end
      ST_T2: begin
        strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CL_ALU, CL_IMM: begin
            strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
          end
          CL_MULDIV: begin
            strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
          end
          CL_NEGNOT: begin
            strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.z_in = 1'b1;
            strobes.operation = opcode;
          end
          CL_LD, CL_LDI, CL_ST: begin
            strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
          end
          CL_BR: begin
            strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_in = 1'b1;
          end
          CL_JR: begin
            strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1;
          end
          CL_IN: begin
            strobes.inport_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
          end
          CL_OUT: begin
            strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.outport_in = 1'b1;
          end
          CL_MFLO: begin
            strobes.lo_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
          end
          CL_MFHI: begin
            strobes.hi_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CL_ALU: begin
            strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.z_in = 1'b1;
            strobes.operation = opcode;
          end
          CL_IMM: begin
            strobes.c_out = 1'b1; strobes.z_in = 1'b1;
            strobes.operation = imm_alu_op(opcode);
          end
          CL_MULDIV: begin
            strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.z_in = 1'b1;
            strobes.operation = opcode;
          end
          CL_NEGNOT: begin
            strobes.z_low_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
          end
          CL_LD, CL_LDI, CL_ST: begin
            strobes.c_out = 1'b1; strobes.z_in = 1'b1; strobes.operation = OP_ADD;
          end
          CL_BR: begin
            strobes.pc_out = 1'b1; strobes.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CL_ALU, CL_IMM, CL_LDI: begin
            strobes.z_low_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
          end
          CL_MULDIV: begin
            strobes.z_low_out = 1'b1; strobes.lo_in = 1'b1;
          end
          CL_LD, CL_ST: begin
            strobes.z_low_out = 1'b1; strobes.mar_in = 1'b1;
          end
          CL_BR: begin
            strobes.c_out = 1'b1; strobes.z_in = 1'b1; strobes.operation = OP_ADD;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CL_MULDIV: begin
            strobes.z_high_out = 1'b1; strobes.hi_in = 1'b1;
          end
          CL_LD: strobes.mdr_read = 1'b1;
          CL_ST: begin
            strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_enable = 1'b1;
          end
          CL_BR: begin
            strobes.z_low_out = con_ff; strobes.pc_in = con_ff;
          end
          default: ;
        endcase
      end
      ST_T6_DONE: begin
        strobes.mdr_read = 1'b1; strobes.mdr_enable = 1'b1;
      end
      ST_T7: begin
        case (cls)
          CL_LD: begin
            strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
          end
          CL_ST: strobes.mem_write = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: strobes.run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control-unit FSM: sequences fetch and execute steps and drives the
// datapath strobes decoded from the current step and the IR opcode.
module control_unit
  import cpu_defs::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            con_ff,
  input  logic            mem_done,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            IRin,
  output logic            MDREnable,
  output logic            MDRread,
  output logic            MDRout,
  output logic            mem_write,
  output logic            Yin,
  output logic            Zin,
  output logic            ZHighOut,
  output logic            ZLowOut,
  output logic            HIin,
  output logic            LOin,
  output logic            HIout,
  output logic            LOout,
  output logic            Cout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            CONin,
  output logic            InportOut,
  output logic            OutportIn,
  output logic [OP_W-1:0] operation,
  output logic            run
);

  state_t          state;
  state_t          state_next;
  logic [OP_W-1:0] opcode;
  op_class_t       cls;
  strobe_t         strobes;
  logic            unused_ir;

  assign opcode    = OP_W'(ir[31 -: OPW]);
  assign unused_ir = ^ir[31-OPW:0];
  assign cls       = classify(opcode);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_RESET;
    else      state <= state_next;
  end

  // Step sequencing; memory waits loop in T1, T6 (ld) and T7 (st).
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:   state_next = ST_T0;
      ST_T0:      state_next = ST_T1;
      ST_T1:      if (mem_done) state_next = ST_T1_DONE;
      ST_T1_DONE: state_next = ST_T2;
      ST_T2: begin
        if (cls == CL_HALT)     state_next = ST_HALT;
        else if (cls == CL_NOP) state_next = ST_T0;
        else                    state_next = ST_T3;
      end
      ST_T3: begin
        case (cls)
          CL_ALU, CL_IMM, CL_MULDIV, CL_NEGNOT, CL_LD, CL_LDI, CL_ST, CL_BR:
            state_next = ST_T4;
          default: state_next = ST_T0;
        endcase
      end
      ST_T4:      state_next = (cls == CL_NEGNOT) ? ST_T0 : ST_T5;
      ST_T5: begin
        case (cls)
          CL_MULDIV, CL_LD, CL_ST, CL_BR: state_next = ST_T6;
          default:                        state_next = ST_T0;
        endcase
      end
      ST_T6: begin
        case (cls)
          CL_LD:   if (mem_done) state_next = ST_T6_DONE;
          CL_ST:   state_next = ST_T7;
          default: state_next = ST_T0;
        endcase
      end
      ST_T6_DONE: state_next = ST_T7;
      ST_T7:      if (cls != CL_ST || mem_done) state_next = ST_T0;
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_RESET;
    endcase
  end

  step_decoder u_step_decoder (
    .state   (state),
    .opcode  (opcode),
    .con_ff  (con_ff),
    .strobes (strobes)
  );

  assign PCout     = strobes.pc_out;
  assign PCin      = strobes.pc_in;
  assign IncPC     = strobes.inc_pc;
  assign MARin     = strobes.mar_in;
  assign IRin      = strobes.ir_in;
  assign MDREnable = strobes.mdr_enable;
  assign MDRread   = strobes.mdr_read;
  assign MDRout    = strobes.mdr_out;
  assign mem_write = strobes.mem_write;
  assign Yin       = strobes.y_in;
  assign Zin       = strobes.z_in;
  assign ZHighOut  = strobes.z_high_out;
  assign ZLowOut   = strobes.z_low_out;
  assign HIin      = strobes.hi_in;
  assign LOin      = strobes.lo_in;
  assign HIout     = strobes.hi_out;
  assign LOout     = strobes.lo_out;
  assign Cout      = strobes.c_out;
  assign Gra       = strobes.gra;
  assign Grb       = strobes.grb;
  assign Grc       = strobes.grc;
  assign Rin       = strobes.r_in;
  assign Rout      = strobes.r_out;
  assign BAout     = strobes.ba_out;
  assign CONin     = strobes.con_in;
  assign InportOut = strobes.inport_out;
  assign OutportIn = strobes.outport_in;
  assign operation = strobes.operation;
  assign run       = strobes.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected step lists built from the
// instruction timing tables, compared every cycle, plus literal spot checks.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr, con_ff, mem_done;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, IRin, MDREnable, MDRread, MDRout, mem_write;
  logic Yin, Zin, ZHighOut, ZLowOut, HIin, LOin, HIout, LOout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, CONin, InportOut, OutportIn;
  logic [4:0] operation;
  logic run;

  always #5 clk = ~clk;

  control_unit #(.OPW(5)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_done(mem_done),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .IRin(IRin),
    .MDREnable(MDREnable), .MDRread(MDRread), .MDRout(MDRout), .mem_write(mem_write),
    .Yin(Yin), .Zin(Zin), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .HIin(HIin),
    .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .CONin(CONin), .InportOut(InportOut), .OutportIn(OutportIn),
    .operation(operation), .run(run)
  );

  typedef logic [26:0] sv_t;
  localparam sv_t PCOUT  = sv_t'(1) << 26;
  localparam sv_t PCIN   = sv_t'(1) << 25;
  localparam sv_t INCPC  = sv_t'(1) << 24;
  localparam sv_t MARIN  = sv_t'(1) << 23;
  localparam sv_t IRIN   = sv_t'(1) << 22;
  localparam sv_t MDREN  = sv_t'(1) << 21;
  localparam sv_t MDRRD  = sv_t'(1) << 20;
  localparam sv_t MDROUT = sv_t'(1) << 19;
  localparam sv_t MEMWR  = sv_t'(1) << 18;
  localparam sv_t YIN    = sv_t'(1) << 17;
  localparam sv_t ZIN    = sv_t'(1) << 16;
  localparam sv_t ZHIGH  = sv_t'(1) << 15;
  localparam sv_t ZLOW   = sv_t'(1) << 14;
  localparam sv_t HIIN   = sv_t'(1) << 13;
  localparam sv_t LOIN   = sv_t'(1) << 12;
  localparam sv_t HIOUT  = sv_t'(1) << 11;
  localparam sv_t LOOUT  = sv_t'(1) << 10;
  localparam sv_t COUT   = sv_t'(1) << 9;
  localparam sv_t GRA    = sv_t'(1) << 8;
  localparam sv_t GRB    = sv_t'(1) << 7;
  localparam sv_t GRC    = sv_t'(1) << 6;
  localparam sv_t RIN    = sv_t'(1) << 5;
  localparam sv_t ROUT   = sv_t'(1) << 4;
  localparam sv_t BAOUT  = sv_t'(1) << 3;
  localparam sv_t CONIN  = sv_t'(1) << 2;
  localparam sv_t INOUT  = sv_t'(1) << 1;
  localparam sv_t OUTIN  = sv_t'(1) << 0;

  typedef struct {
    sv_t        s;
    logic [4:0] op;
    logic       md;
    logic       rn;
  } step_t;

  step_t      exp_q[$];
  sv_t        cap_s[$];
  logic [4:0] cap_op[$];
  int checks = 0;
  int errors = 0;

  function automatic sv_t act_s();
    return {PCout, PCin, IncPC, MARin, IRin, MDREnable, MDRread, MDRout, mem_write,
            Yin, Zin, ZHighOut, ZLowOut, HIin, LOin, HIout, LOout, Cout,
            Gra, Grb, Grc, Rin, Rout, BAout, CONin, InportOut, OutportIn};
  endfunction

  task automatic check(input string nm, input int cyc, input sv_t es,
                       input logic [4:0] eo, input logic er);
    sv_t a;
    a = act_s();
    checks++;
    if (a !== es || operation !== eo || run !== er) begin
      errors++;
      $display("FAIL %s cycle %0d: got strobes=%h op=%b run=%b, expected strobes=%h op=%b run=%b",
               nm, cyc, a, operation, run, es, eo, er);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  task automatic push(input sv_t s, input logic [4:0] o = 5'd0,
                      input logic md = 1'b0, input logic rn = 1'b1);
    step_t e;
    e.s = s; e.op = o; e.md = md; e.rn = rn;
    exp_q.push_back(e);
  endtask

  // Expected per-cycle behaviour of one instruction; fw/mw = wait cycles
  // before mem_done (mem_done is high in the last of them).
  task automatic model(input logic [4:0] opc, input logic con, input int fw, input int mw);
    push(PCOUT | MARIN | INCPC | ZIN);
    for (int i = 0; i < fw; i++) push(ZLOW | PCIN | MDRRD, 5'd0, i == fw - 1);
    push(ZLOW | PCIN | MDRRD | MDREN);
    push(MDROUT | IRIN);
    if (opc >= 5'd3 && opc <= 5'd11) begin
      push(GRB | ROUT | YIN); push(GRC | ROUT | ZIN, opc); push(ZLOW | GRA | RIN);
    end else if (opc >= 5'd12 && opc <= 5'd14) begin
      push(GRB | ROUT | YIN);
      push(COUT | ZIN, (opc == 5'd12) ? 5'd3 : (opc == 5'd13) ? 5'd5 : 5'd6);
      push(ZLOW | GRA | RIN);
    end else if (opc == 5'd15 || opc == 5'd16) begin
      push(GRA | ROUT | YIN); push(GRB | ROUT | ZIN, opc);
      push(ZLOW | LOIN); push(ZHIGH | HIIN);
    end else if (opc == 5'd17 || opc == 5'd18) begin
      push(GRB | ROUT | ZIN, opc); push(ZLOW | GRA | RIN);
    end else if (opc <= 5'd2) begin
      push(GRB | BAOUT | YIN); push(COUT | ZIN, 5'd3);
      if (opc == 5'd1) push(ZLOW | GRA | RIN);
      else if (opc == 5'd0) begin
        push(ZLOW | MARIN);
        for (int i = 0; i < mw; i++) push(MDRRD, 5'd0, i == mw - 1);
        push(MDRRD | MDREN);
        push(MDROUT | GRA | RIN);
      end else begin
        push(ZLOW | MARIN); push(GRA | ROUT | MDREN);
        for (int i = 0; i < mw; i++) push(MEMWR, 5'd0, i == mw - 1);
      end
    end else if (opc == 5'd19) begin
      push(GRA | ROUT | CONIN); push(PCOUT | YIN); push(COUT | ZIN, 5'd3);
      push(con ? (ZLOW | PCIN) : sv_t'(0));
    end else if (opc == 5'd21) push(GRA | ROUT | PCIN);
    else if (opc == 5'd22) push(INOUT | GRA | RIN);
    else if (opc == 5'd23) push(GRA | ROUT | OUTIN);
    else if (opc == 5'd24) push(LOOUT | GRA | RIN);
    else if (opc == 5'd25) push(HIOUT | GRA | RIN);
    else if (opc == 5'd27) begin
      for (int i = 0; i < 20; i++) push(sv_t'(0), 5'd0, 1'b0, 1'b0);
    end
  endtask

  // Drive one instruction starting at T0 and compare every cycle.
  task automatic run_instr(input string nm, input logic [4:0] opc, input logic con,
                           input int fw, input int mw, input int limit);
    exp_q.delete(); cap_s.delete(); cap_op.delete();
    model(opc, con, fw, mw);
    for (int i = 0; i < exp_q.size() && (limit < 0 || i < limit); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        ir = {opc, 27'h0155AA};
        con_ff = con;
      end
      mem_done = exp_q[i].md;
      @(negedge clk);
      check(nm, i, exp_q[i].s, exp_q[i].op, exp_q[i].rn);
      cap_s.push_back(act_s());
      cap_op.push_back(operation);
    end
  endtask

  initial begin
    int rd_cnt, en_cnt;
    clr = 1'b0; con_ff = 1'b0; mem_done = 1'b0; ir = 32'h0;
    #12;
    check("reset", 0, sv_t'(0), 5'd0, 1'b1);
    @(negedge clk); clr = 1'b1;

    run_instr("add", 5'b00011, 1'b0, 1, 1, -1);
    lit("add_len", 32'(exp_q.size()), 32'd7);
    lit("add_t0", 32'(cap_s[0]), 32'(PCOUT | MARIN | INCPC | ZIN));
    lit("add_t4", 32'(cap_s[5]), 32'(GRC | ROUT | ZIN));
    lit("add_t4_op", 32'(cap_op[5]), 32'd3);

    run_instr("ld", 5'b00000, 1'b0, 1, 3, -1);
    lit("ld_len", 32'(exp_q.size()), 32'd12);
    rd_cnt = 0; en_cnt = 0;
    foreach (cap_s[k]) begin
      if ((cap_s[k] & (MDRRD | PCIN)) == MDRRD) rd_cnt++;
      if ((cap_s[k] & (MDREN | PCIN)) == MDREN) en_cnt++;
    end
    lit("ld_mdrread_cycles", 32'(rd_cnt), 32'd4);
    lit("ld_mdrenable_pulses", 32'(en_cnt), 32'd1);
    lit("ld_t7", 32'(cap_s[11]), 32'(MDROUT | GRA | RIN));

    run_instr("br_c0", 5'b10011, 1'b0, 1, 1, -1);
    lit("br_c0_t6_pcin", 32'(cap_s[7] & PCIN), 32'd0);
    run_instr("br_c1", 5'b10011, 1'b1, 2, 1, -1);
    lit("br_c1_t6_pcin", 32'(cap_s[8] & PCIN), 32'(PCIN));

    run_instr("mul", 5'b10000, 1'b0, 1, 1, -1);
    lit("mul_t4_op", 32'(cap_op[5]), 32'h10);
    lit("mul_t5", 32'(cap_s[6]), 32'(ZLOW | LOIN));
    lit("mul_t6", 32'(cap_s[7]), 32'(ZHIGH | HIIN));

    run_instr("div", 5'b01111, 1'b0, 1, 1, -1);
    run_instr("sub", 5'b00100, 1'b0, 2, 1, -1);
    run_instr("shl", 5'b01011, 1'b0, 1, 1, -1);
    run_instr("addi", 5'b01100, 1'b0, 1, 1, -1);
    lit("addi_t4_op", 32'(cap_op[5]), 32'd3);
    run_instr("andi", 5'b01101, 1'b0, 1, 1, -1);
    run_instr("ori", 5'b01110, 1'b0, 1, 1, -1);
    run_instr("ldi", 5'b00001, 1'b0, 1, 1, -1);
    run_instr("st", 5'b00010, 1'b0, 3, 2, -1);
    run_instr("neg", 5'b10001, 1'b0, 1, 1, -1);
    run_instr("not", 5'b10010, 1'b0, 1, 1, -1);
    run_instr("jr", 5'b10101, 1'b0, 1, 1, -1);
    run_instr("in", 5'b10110, 1'b0, 1, 1, -1);
    run_instr("out", 5'b10111, 1'b0, 1, 1, -1);
    run_instr("mflo", 5'b11000, 1'b0, 1, 1, -1);
    run_instr("mfhi", 5'b11001, 1'b0, 1, 1, -1);
    run_instr("nop", 5'b11010, 1'b0, 1, 1, -1);
    lit("nop_len", 32'(exp_q.size()), 32'd4);
    run_instr("undef_10100", 5'b10100, 1'b0, 1, 1, -1);
    run_instr("undef_11111", 5'b11111, 1'b0, 1, 1, -1);

    run_instr("halt", 5'b11011, 1'b0, 1, 1, -1);
    #2 clr = 1'b0;
    #1 check("halt_clr", 0, sv_t'(0), 5'd0, 1'b1);
    @(negedge clk); clr = 1'b1;
    run_instr("after_halt", 5'b00011, 1'b0, 1, 1, -1);

    // Abort a store while it waits in T7.
    run_instr("st_abort", 5'b00010, 1'b0, 1, 5, 10);
    lit("st_abort_memwr_before", 32'(mem_write), 32'd1);
    #2 clr = 1'b0;
    #1 lit("st_abort_memwr_async", 32'(mem_write), 32'd0);
    check("st_abort_reset", 0, sv_t'(0), 5'd0, 1'b1);
    @(negedge clk);
    check("st_abort_held", 1, sv_t'(0), 5'd0, 1'b1);
    clr = 1'b1;
    run_instr("after_abort", 5'b01100, 1'b0, 1, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
